// File: rtl/crc5_token_tx.sv
// Serial CRC-5 token frame transmitter: 11 message bits MSB first followed by the
// inverted CRC-5 (x^5+x^2+1, seed 5'h1F), with frame strobes and an optional idle gap.
module crc5_token_tx #(
    parameter int GAP = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] msg,
    input  logic        msg_valid,
    output logic        msg_ready,
    output logic        tx_bit,
    output logic        tx_en,
    output logic        tx_sof,
    output logic        tx_eof
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CRC  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);
    localparam logic       GAP_ZERO = (GAP == 0);

    function automatic logic [4:0] f_crc5_step(input logic [4:0] crc, input logic d);
        logic fb;
        fb = d ^ crc[4];
        return {crc[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    endfunction

    state_t      r_state;
    state_t      w_state_nx;
    logic [10:0] r_sh;
    logic [4:0]  r_crc;
    logic [3:0]  r_cnt;
    logic [3:0]  r_gcnt;
    logic        w_accept;
    logic        w_last_crc;
    logic [4:0]  w_crc_step;
    logic        w_bit_nx;
    logic        w_en_nx;
    logic        w_sof_nx;
    logic        w_eof_nx;

    // r_crc holds the CRC of the bits already sent; r_sh[10] is the bit on the wire
    assign w_last_crc = (r_state == ST_CRC) && (r_cnt == 4'd4);
    assign msg_ready  = (r_state == ST_IDLE) || (GAP_ZERO && w_last_crc);
    assign w_accept   = msg_valid && msg_ready;
    assign w_crc_step = f_crc5_step(r_crc, r_sh[10]);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nx = ST_DATA;
                else          w_state_nx = ST_IDLE;
            end
            ST_DATA: begin
                if (r_cnt == 4'd10) w_state_nx = ST_CRC;
                else                w_state_nx = ST_DATA;
            end
            ST_CRC: begin
                if (!w_last_crc)   w_state_nx = ST_CRC;
                else if (w_accept) w_state_nx = ST_DATA;
                else if (GAP_ZERO) w_state_nx = ST_IDLE;
                else               w_state_nx = ST_GAP;
            end
            ST_GAP: begin
                if (r_gcnt == GAP_LAST) w_state_nx = ST_IDLE;
                else                    w_state_nx = ST_GAP;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Output logic: values the serial outputs take after the coming edge
    always_comb begin
        w_bit_nx = 1'b0;
        w_en_nx  = (w_state_nx == ST_DATA) || (w_state_nx == ST_CRC);
        w_sof_nx = w_accept;
        w_eof_nx = (r_state == ST_CRC) && (r_cnt == 4'd3);
        if (w_accept) begin
            w_bit_nx = msg[10];
        end else if (r_state == ST_DATA) begin
            w_bit_nx = (r_cnt == 4'd10) ? ~w_crc_step[4] : r_sh[9];
        end else if ((r_state == ST_CRC) && !w_last_crc) begin
            w_bit_nx = ~r_crc[3];
        end else begin
            w_bit_nx = 1'b0;
        end
    end

    // Registered serial outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_bit <= 1'b0;
            tx_en  <= 1'b0;
            tx_sof <= 1'b0;
            tx_eof <= 1'b0;
        end else begin
            tx_bit <= w_bit_nx;
            tx_en  <= w_en_nx;
            tx_sof <= w_sof_nx;
            tx_eof <= w_eof_nx;
        end
    end

    // Shift register, CRC and counters; an accept overrides frame progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sh   <= 11'd0;
            r_crc  <= 5'h1F;
            r_cnt  <= 4'd0;
            r_gcnt <= 4'd0;
        end else if (w_accept) begin
            r_sh   <= msg;
            r_crc  <= 5'h1F;
            r_cnt  <= 4'd0;
            r_gcnt <= 4'd0;
        end else if (r_state == ST_DATA) begin
            r_sh   <= {r_sh[9:0], 1'b0};
            r_crc  <= w_crc_step;
            r_cnt  <= (r_cnt == 4'd10) ? 4'd0 : r_cnt + 4'd1;
            r_gcnt <= 4'd0;
        end else if (r_state == ST_CRC) begin
            r_sh   <= r_sh;
            r_crc  <= {r_crc[3:0], 1'b0};
            r_cnt  <= w_last_crc ? 4'd0 : r_cnt + 4'd1;
            r_gcnt <= 4'd0;
        end else if (r_state == ST_GAP) begin
            r_sh   <= r_sh;
            r_crc  <= r_crc;
            r_cnt  <= 4'd0;
            r_gcnt <= (r_gcnt == GAP_LAST) ? 4'd0 : r_gcnt + 4'd1;
        end else begin
            r_sh   <= r_sh;
            r_crc  <= r_crc;
            r_cnt  <= 4'd0;
            r_gcnt <= 4'd0;
        end
    end

endmodule

// File: tb/tb_crc5_token_tx.sv
// Directed bench for crc5_token_tx: one instance with GAP=0, one with GAP=3,
// frames compared against hand-computed 16-bit bit patterns.
module tb_crc5_token_tx;

    logic        clk;
    logic        rst;
    logic [10:0] msg;
    logic        valid0, valid3;
    logic        msg_ready0, tx_bit0, tx_en0, tx_sof0, tx_eof0;
    logic        msg_ready3, tx_bit3, tx_en3, tx_sof3, tx_eof3;

    int n_vec = 0;
    int n_bad = 0;

    crc5_token_tx #(.GAP(0)) u_dut0 (
        .clk(clk), .rst(rst), .msg(msg), .msg_valid(valid0), .msg_ready(msg_ready0),
        .tx_bit(tx_bit0), .tx_en(tx_en0), .tx_sof(tx_sof0), .tx_eof(tx_eof0)
    );

    crc5_token_tx #(.GAP(3)) u_dut3 (
        .clk(clk), .rst(rst), .msg(msg), .msg_valid(valid3), .msg_ready(msg_ready3),
        .tx_bit(tx_bit3), .tx_en(tx_en3), .tx_sof(tx_sof3), .tx_eof(tx_eof3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Receiver-side residue over a full 16-bit frame
    function automatic logic [4:0] residue(input logic [15:0] fr);
        logic [4:0] c;
        logic       fb;
        c = 5'h1F;
        for (int i = 15; i >= 0; i--) begin
            fb = fr[i] ^ c[4];
            c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        end
        return c;
    endfunction

    // Collect n cycles of outputs (MSB = first cycle), sampled on falling edges
    task automatic grab(input bit sel, input int n,
                        output logic [15:0] b, output logic [15:0] e, output logic [15:0] s,
                        output logic [15:0] f, output logic [15:0] r);
        b = 16'd0; e = 16'd0; s = 16'd0; f = 16'd0; r = 16'd0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            b = {b[14:0], sel ? tx_bit3    : tx_bit0};
            e = {e[14:0], sel ? tx_en3     : tx_en0};
            s = {s[14:0], sel ? tx_sof3    : tx_sof0};
            f = {f[14:0], sel ? tx_eof3    : tx_eof0};
            r = {r[14:0], sel ? msg_ready3 : msg_ready0};
        end
    endtask

    task automatic send0(input logic [10:0] m);
        @(negedge clk);
        msg    = m;
        valid0 = 1'b1;
        @(posedge clk);
        #1 valid0 = 1'b0;
    endtask

    logic [15:0] b, e, s, f, r;
    logic [15:0] b2, e2, s2, f2, r2;
    int          eof_cnt;

    initial begin
        rst = 1'b0; valid0 = 1'b0; valid3 = 1'b0; msg = 11'd0;
        repeat (2) @(negedge clk);
        chk("reset_out0", {tx_bit0, tx_en0, tx_sof0, tx_eof0, msg_ready0}, 5'b00001);
        chk("reset_out3", {tx_bit3, tx_en3, tx_sof3, tx_eof3, msg_ready3}, 5'b00001);
        rst = 1'b1;

        // Scenario 1: all-zero message
        send0(11'h000);
        grab(1'b0, 16, b, e, s, f, r);
        chk("s1_bits", b, 16'h0008);
        chk("s1_en", e, 16'hFFFF);
        chk("s1_sof_eof", {s, f}, {16'h8000, 16'h0001});
        chk("s1_residue", residue(b), 5'b01100);
        @(negedge clk);
        chk("s1_idle_after", {tx_en0, tx_bit0, msg_ready0}, 3'b001);

        // Scenario 2: all-ones message
        send0(11'h7FF);
        grab(1'b0, 16, b, e, s, f, r);
        chk("s2_bits", b, 16'hFFE2);
        chk("s2_en", e, 16'hFFFF);
        chk("s2_ready", r, 16'h0001);
        chk("s2_residue", residue(b), 5'b01100);
        @(negedge clk);
        chk("s2_en_after", tx_en0, 1'b0);

        // Scenario 3: back-to-back with valid held high
        @(negedge clk);
        msg = 11'h000; valid0 = 1'b1;
        @(posedge clk);
        #1 msg = 11'h7FF;
        grab(1'b0, 16, b, e, s, f, r);
        @(posedge clk);
        #1 valid0 = 1'b0;
        grab(1'b0, 16, b2, e2, s2, f2, r2);
        chk("s3_bits", {b, b2}, {16'h0008, 16'hFFE2});
        chk("s3_en32", {e, e2}, 32'hFFFF_FFFF);
        chk("s3_eof_sof_adj", {f[0], s2[15], s[15], f2[0]}, 4'b1111);
        @(negedge clk);
        chk("s3_en_after", tx_en0, 1'b0);

        // Scenario 4: GAP=3 with two queued messages
        @(negedge clk);
        msg = 11'h000; valid3 = 1'b1;
        @(posedge clk);
        #1 msg = 11'h7FF;
        grab(1'b1, 16, b, e, s, f, r);
        chk("s4_bits", b, 16'h0008);
        chk("s4_ready_busy", r, 16'h0000);
        chk("s4_eof", f, 16'h0001);
        grab(1'b1, 4, b2, e2, s2, f2, r2);
        chk("s4_gap_en", e2[3:0], 4'b0000);
        chk("s4_gap_ready", r2[3:0], 4'b0001);
        @(negedge clk);
        valid3 = 1'b0;
        chk("s4_second_first", {tx_en3, tx_sof3, tx_bit3, msg_ready3}, 4'b1110);
        grab(1'b1, 15, b2, e2, s2, f2, r2);
        chk("s4_second_rest", b2[14:0], 15'h7FE2);
        repeat (5) @(negedge clk);

        // Scenario 5: reset mid-frame
        send0(11'h2AB);
        repeat (7) @(negedge clk);
        chk("s5_bit7_en", tx_en0, 1'b1);
        rst = 1'b0;
        #1;
        chk("s5_reset_out", {tx_bit0, tx_en0, tx_sof0, tx_eof0, msg_ready0}, 5'b00001);
        eof_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 2) rst = 1'b1;
            if (tx_eof0) eof_cnt++;
        end
        chk("s5_no_eof", eof_cnt, 0);
        send0(11'h000);
        grab(1'b0, 16, b, e, s, f, r);
        chk("s5_resend_bits", b, 16'h0008);
        chk("s5_resend_strobes", {s, f}, {16'h8000, 16'h0001});

        // Scenario 6: input churn while busy
        send0(11'h5A3);
        b = 16'd0; s = 16'd0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            b = {b[14:0], tx_bit0};
            s = {s[14:0], tx_sof0};
            msg    = 11'($urandom);
            valid0 = (i < 15) ? i[0] : 1'b0;
        end
        chk("s6_bits", b, 16'hB47B);
        chk("s6_residue", residue(b), 5'b01100);
        chk("s6_single_sof", s, 16'h8000);
        @(negedge clk);
        chk("s6_no_extra", {tx_en0, tx_sof0}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
